if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 78 +++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register with redirect/stall control and the IF/ID pipeline register.
// Define IF_FETCH_CNT_EN to add the fetch_cnt_o counter of instructions accepted into IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic [31:0] pc_next;
  logic        ifid_load;

  assign pc_plus4        = pc_o + 32'd4;
  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign imem_addr_o     = pc_o;

  // A redirect wins over a stall so a resolved branch is never lost while IF/ID is held.
  always_comb begin
    pc_next   = pc_plus4;
    ifid_load = 1'b0;
    if (redirect_i) begin
      pc_next = redirect_target;
    end else if (stall_i) begin
      pc_next = pc_o;
    end
    if (!flush_i && !stall_i) begin
      ifid_load = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o <= RESET_PC;
    end else begin
      pc_o <= pc_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ifid_instr_o <= NOP_INSTR;
      ifid_pc4_o   <= 32'd0;
      ifid_valid_o <= 1'b0;
    end else if (ifid_load) begin
      ifid_instr_o <= imem_instr_i;
      ifid_pc4_o   <= pc_plus4;
      ifid_valid_o <= 1'b1;
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= 32'd0;
    end else if (ifid_load) begin
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end
`endif

endmodule
